dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port data-memory controller shared between the core load/store unit (core port) and the program/data loader (loader port). It arbitrates requests, performs RV32I byte/halfword/word formatting (byte-enables, store replication, load sign/zero extension), flags misaligned or illegal core accesses, and sequences one memory transaction at a time with a fixed memory latency. It sits between the datapath's load/store stage and the data memory instance.

## Interface
- ADDR_W, 32, byte address width
- MEM_LATENCY, 1, cycles from m_en to valid m_rdata (≥1)
- STARVE_MAX, 4, consecutive loader grants allowed while core waits

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- c_req  in  1  core request, held until c_gnt
- c_we  in  1  core store (1) / load (0)
- c_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- c_addr  in  ADDR_W  core byte address
- c_wdata  in  32  core store data (LSB-aligned)
- c_gnt  out  1  core request accepted this cycle
- c_err  out  1  misaligned/illegal access, pulses with c_gnt
- c_rvalid  out  1  core response valid (loads and stores)
- c_rdata  out  32  formatted load data; 0 for stores
- l_req, l_we  in  1  loader request / store
- l_addr  in  ADDR_W  loader byte address (word accesses only, addr[1:0] ignored)
- l_wdata  in  32  loader store data
- l_gnt, l_rvalid  out  1  loader grant / response valid
- l_rdata  out  32  raw memory word
- m_en, m_we  out  1  memory access strobe / write
- m_be  out  4  byte enables
- m_addr  out  ADDR_W-2  word address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data

## Operation
- FSM: IDLE, ACCESS, WAIT. IDLE: grant one request (combinational gnt). Grant → ACCESS (m_en one cycle) → WAIT (MEM_LATENCY−1 cycles, counter) → response cycle, which is also IDLE (new grant allowed same cycle).
- Arbitration: loader has priority. Counter counts consecutive loader grants while c_req is high; at STARVE_MAX the next grant goes to core if c_req; counter clears on any core grant or when c_req low.
- Request fields sampled in grant cycle into command registers; requester may change them afterward.
- Core legality: H/HU with addr[0]=1, W with addr[1:0]≠0, funct3 ∈ {011,110,111}, or store with funct3 ∈ {100,101} → c_gnt and c_err pulse together, no memory access, no c_rvalid, FSM stays IDLE, starvation counter treats it as a core grant.
- Stores: SB m_be = 1<<addr[1:0], m_wdata = byte×4; SH m_be = addr[1]?1100:0011, m_wdata = half×2; SW/loader m_be = 1111.
- Loads: m_be = 1111; response selects byte by addr[1:0] or half by addr[1]; B/H sign-extend, BU/HU zero-extend, W raw. Loader rdata raw.
- Only the granted port's rvalid pulses; other port's rdata = 0.

## Timing
- Reset (async): FSM IDLE, counters 0, all outputs 0 (gnt, err, rvalid, rdata, m_en, m_we, m_be, m_addr, m_wdata).
- Grant cycle T; m_en/m_we/m_be/m_addr/m_wdata registered, valid in T+1 only (m_en/m_we 0 otherwise).
- rvalid pulses one cycle at T+1+MEM_LATENCY; rdata formatted combinationally from m_rdata that cycle.
- Throughput: one access per 1+MEM_LATENCY cycles; c_gnt/l_gnt never both high; no gnt in ACCESS/WAIT.
- Reset mid-transaction: in-flight access dropped, no rvalid after release.

## Test plan
- Core LW addr 0x10, mem[4]=0x800000FF, MEM_LATENCY=1 → c_gnt T; T+1 m_en=1, m_addr=0x4, m_be=1111, m_we=0; T+2 c_rvalid=1, c_rdata=0x800000FF.
- mem[4]=0x80FF7F01: LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF80FF; LHU 0x10 → 0x00007F01; LB 0x10 → 0x00000001.
- SB 0x11 wdata 0x000000AB → m_be=0010, m_wdata=0xABABABAB; SH 0x12 wdata 0x1234 → m_be=1100, m_wdata=0x12341234; store ack c_rvalid with c_rdata=0.
- Core LW 0x02, LH 0x05, funct3=011 → c_gnt+c_err same cycle, m_en stays 0, no c_rvalid.
- c_req and l_req held high, STARVE_MAX=4 → grant order L,L,L,L,C,L,L,L,L,C, grants spaced 2 cycles (MEM_LATENCY=1).
- rst_n low at T+1 after a load grant → all outputs 0 immediately; after release no c_rvalid, next request granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory controller shared by core LSU and loader.
// One transaction at a time, fixed memory latency.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_funct3,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_err,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-3:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  state_t      state;
  logic [SW-1:0] starve;
  logic [15:0] wait_cnt;
  logic        resp;
  logic        own_core;
  logic        cmd_we;
  logic [2:0]  cmd_f3;
  logic [1:0]  cmd_a;

  logic        idle_ok;
  logic        starve_hit;
  logic        c_bad;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] fmt;

  assign idle_ok    = rst_n && (state == IDLE);
  assign starve_hit = (starve == SW'(STARVE_MAX));

  // Grant decode: loader first unless the core has starved
  always_comb begin
    l_gnt = idle_ok && l_req &&
            !(c_req && starve_hit);
    c_gnt = idle_ok && c_req &&
            (!l_req || starve_hit);
    c_err = c_gnt && c_bad;
  end

  // Core access legality by width and alignment
  always_comb begin
    c_bad = 1'b0;
    unique case (c_funct3)
      3'b000:  c_bad = 1'b0;
      3'b001:  c_bad = c_addr[0];
      3'b010:  c_bad = |c_addr[1:0];
      3'b100:  c_bad = c_we;
      3'b101:  c_bad = c_we | c_addr[0];
      default: c_bad = 1'b1;
    endcase
  end

  // Byte-enable and lane replication for core stores
  always_comb begin
    st_be = 4'hf;
    st_wd = c_wdata;
    if (c_we) begin
      unique case (1'b1)
        c_funct3[1:0] == 2'b00: begin
          st_be = 4'b0001 << c_addr[1:0];
          st_wd = {4{c_wdata[7:0]}};
        end
        c_funct3[1:0] == 2'b01: begin
          st_be = c_addr[1] ? 4'b1100
                            : 4'b0011;
          st_wd = {2{c_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane select and extension of load data
  always_comb begin
    lh = cmd_a[1] ? m_rdata[31:16]
                  : m_rdata[15:0];
    unique case (cmd_a)
      2'd0:    lb = m_rdata[7:0];
      2'd1:    lb = m_rdata[15:8];
      2'd2:    lb = m_rdata[23:16];
      default: lb = m_rdata[31:24];
    endcase
    unique case (cmd_f3)
      3'b000:  fmt = {{24{lb[7]}}, lb};
      3'b001:  fmt = {{16{lh[15]}}, lh};
      3'b100:  fmt = {24'd0, lb};
      3'b101:  fmt = {16'd0, lh};
      default: fmt = m_rdata;
    endcase
  end

  assign c_rvalid = resp && own_core;
  assign l_rvalid = resp && !own_core;
  assign c_rdata  = (c_rvalid && !cmd_we)
                    ? fmt : 32'd0;
  assign l_rdata  = (l_rvalid && !cmd_we)
                    ? m_rdata : 32'd0;

  // Transaction FSM, command capture and memory strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      starve   <= '0;
      wait_cnt <= '0;
      resp     <= 1'b0;
      own_core <= 1'b0;
      cmd_we   <= 1'b0;
      cmd_f3   <= 3'd0;
      cmd_a    <= 2'd0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'd0;
      m_addr   <= '0;
      m_wdata  <= 32'd0;
    end else begin
      resp <= 1'b0;
      m_en <= 1'b0;
      m_we <= 1'b0;
      if (!c_req || c_gnt)
        starve <= '0;
      else if (l_gnt && !starve_hit)
        starve <= starve + 1'b1;
      unique case (state)
        IDLE: begin
          if (l_gnt) begin
            state    <= ACCESS;
            own_core <= 1'b0;
            cmd_we   <= l_we;
            cmd_f3   <= 3'b010;
            cmd_a    <= 2'd0;
            m_en     <= 1'b1;
            m_we     <= l_we;
            m_be     <= 4'hf;
            m_addr   <= l_addr[ADDR_W-1:2];
            m_wdata  <= l_wdata;
          end else if (c_gnt && !c_bad) begin
            state    <= ACCESS;
            own_core <= 1'b1;
            cmd_we   <= c_we;
            cmd_f3   <= c_funct3;
            cmd_a    <= c_addr[1:0];
            m_en     <= 1'b1;
            m_we     <= c_we;
            m_be     <= st_be;
            m_addr   <= c_addr[ADDR_W-1:2];
            m_wdata  <= st_wd;
          end
        end
        ACCESS: begin
          if (MEM_LATENCY <= 1) begin
            state <= IDLE;
            resp  <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= 16'(MEM_LATENCY - 2);
          end
        end
        WAIT: begin
          if (wait_cnt == 16'd0) begin
            state <= IDLE;
            resp  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word memory model.
// Latency 1, starvation limit 4.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we;
  logic [2:0]  c_funct3;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_err, c_rvalid;
  logic [31:0] c_rdata;
  logic        l_req, l_we;
  logic [31:0] l_addr, l_wdata;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        m_en, m_we;
  logic [3:0]  m_be;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'd0;

  logic [31:0] mem [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32),
    .MEM_LATENCY(1),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we),
    .c_funct3(c_funct3), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_gnt(c_gnt),
    .c_err(c_err), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we),
    .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // One-cycle memory with byte-enabled writes
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we)
        for (int b = 0; b < 4; b++)
          if (m_be[b])
            mem[m_addr[3:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      m_rdata <= mem[m_addr[3:0]];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic core_op(input string tag,
                         input logic we,
                         input logic [2:0] f3,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input logic [3:0] be,
                         input logic [31:0] mwd,
                         input logic [31:0] rd);
    @(negedge clk);
    c_req = 1'b1; c_we = we; c_funct3 = f3;
    c_addr = addr; c_wdata = wd;
    #1;
    check({tag, " gnt"}, 32'(c_gnt), 32'd1);
    check({tag, " err"}, 32'(c_err), 32'd0);
    @(posedge clk); #1;
    c_req = 1'b0; c_addr = 32'hFFFF_FFFF;
    c_wdata = 32'd0;
    check({tag, " m_en"}, 32'(m_en), 32'd1);
    check({tag, " m_we"}, 32'(m_we), 32'(we));
    check({tag, " m_be"}, 32'(m_be), 32'(be));
    check({tag, " m_addr"}, 32'(m_addr),
          addr >> 2);
    if (we)
      check({tag, " m_wdata"}, m_wdata, mwd);
    @(posedge clk); #1;
    check({tag, " rvalid"}, 32'(c_rvalid), 32'd1);
    check({tag, " rdata"}, c_rdata, rd);
    check({tag, " m_en off"}, 32'(m_en), 32'd0);
  endtask

  task automatic err_op(input string tag,
                        input logic we,
                        input logic [2:0] f3,
                        input logic [31:0] addr);
    @(negedge clk);
    c_req = 1'b1; c_we = we; c_funct3 = f3;
    c_addr = addr; c_wdata = 32'h5555_5555;
    #1;
    check({tag, " gnt"}, 32'(c_gnt), 32'd1);
    check({tag, " err"}, 32'(c_err), 32'd1);
    @(posedge clk); #1;
    c_req = 1'b0;
    check({tag, " m_en"}, 32'(m_en), 32'd0);
    @(posedge clk); #1;
    check({tag, " rvalid"}, 32'(c_rvalid), 32'd0);
  endtask

  task automatic l_op(input string tag,
                      input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic [31:0] rd);
    @(negedge clk);
    l_req = 1'b1; l_we = we;
    l_addr = addr; l_wdata = wd;
    #1;
    check({tag, " gnt"}, 32'(l_gnt), 32'd1);
    @(posedge clk); #1;
    l_req = 1'b0;
    check({tag, " m_be"}, 32'(m_be), 32'hf);
    check({tag, " m_addr"}, 32'(m_addr),
          addr >> 2);
    if (we)
      check({tag, " m_wdata"}, m_wdata, wd);
    @(posedge clk); #1;
    check({tag, " rvalid"}, 32'(l_rvalid), 32'd1);
    if (!we)
      check({tag, " rdata"}, l_rdata, rd);
    check({tag, " c_rvalid"}, 32'(c_rvalid), 32'd0);
  endtask

  logic [9:0] order;
  int         gcyc [0:9];
  int         ng;
  int         both;
  int         extra;

  initial begin
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010;
    c_addr = 32'h10; c_wdata = 32'd0;
    l_req = 1'b0; l_we = 1'b0;
    l_addr = 32'd0; l_wdata = 32'd0;
    #12;
    check("rst c_gnt", 32'(c_gnt), 32'd0);
    check("rst m_en", 32'(m_en), 32'd0);
    check("rst m_be", 32'(m_be), 32'd0);
    check("rst m_addr", 32'(m_addr), 32'd0);
    check("rst m_wdata", m_wdata, 32'd0);
    check("rst c_rvalid", 32'(c_rvalid), 32'd0);
    check("rst c_rdata", c_rdata, 32'd0);
    c_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    l_op("L sw", 1'b1, 32'h10, 32'h8000_00FF, 32'd0);
    core_op("LW", 1'b0, 3'b010, 32'h10, 32'd0,
            4'hf, 32'd0, 32'h8000_00FF);
    l_op("L sw2", 1'b1, 32'h10, 32'h80FF_7F01, 32'd0);
    l_op("L lw", 1'b0, 32'h13, 32'd0, 32'h80FF_7F01);

    core_op("LB13", 1'b0, 3'b000, 32'h13, 32'd0,
            4'hf, 32'd0, 32'hFFFF_FF80);
    core_op("LBU13", 1'b0, 3'b100, 32'h13, 32'd0,
            4'hf, 32'd0, 32'h0000_0080);
    core_op("LH12", 1'b0, 3'b001, 32'h12, 32'd0,
            4'hf, 32'd0, 32'hFFFF_80FF);
    core_op("LHU10", 1'b0, 3'b101, 32'h10, 32'd0,
            4'hf, 32'd0, 32'h0000_7F01);
    core_op("LB10", 1'b0, 3'b000, 32'h10, 32'd0,
            4'hf, 32'd0, 32'h0000_0001);

    core_op("SB11", 1'b1, 3'b000, 32'h11,
            32'h0000_00AB, 4'b0010,
            32'hABAB_ABAB, 32'd0);
    core_op("SH12", 1'b1, 3'b001, 32'h12,
            32'h0000_1234, 4'b1100,
            32'h1234_1234, 32'd0);
    core_op("LW post", 1'b0, 3'b010, 32'h10, 32'd0,
            4'hf, 32'd0, 32'h1234_AB01);

    err_op("LW02", 1'b0, 3'b010, 32'h02);
    err_op("LH05", 1'b0, 3'b001, 32'h05);
    err_op("F011", 1'b0, 3'b011, 32'h00);
    err_op("SBU", 1'b1, 3'b100, 32'h00);

    // Both ports held: four loader grants then one core grant
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010;
    c_addr = 32'h10;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
    order = '0; ng = 0; both = 0;
    for (int cy = 0; cy < 40; cy++) begin
      #1;
      if (c_gnt && l_gnt) both++;
      if ((c_gnt || l_gnt) && ng < 10) begin
        order[ng] = c_gnt;
        gcyc[ng] = cy;
        ng++;
      end
      @(negedge clk);
    end
    c_req = 1'b0; l_req = 1'b0;
    check("starve count", 32'(ng), 32'd10);
    check("starve order", 32'(order),
          32'b10_0001_0000);
    check("starve both", 32'(both), 32'd0);
    check("starve spacing", 32'(gcyc[9] - gcyc[0]),
          32'd18);
    check("starve step", 32'(gcyc[5] - gcyc[4]),
          32'd2);

    // Reset during an in-flight load
    repeat (3) @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010;
    c_addr = 32'h10;
    #1;
    check("rstmid gnt", 32'(c_gnt), 32'd1);
    @(posedge clk); #1;
    c_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid m_en", 32'(m_en), 32'd0);
    check("rstmid m_addr", 32'(m_addr), 32'd0);
    check("rstmid rvalid", 32'(c_rvalid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    for (int cy = 0; cy < 4; cy++) begin
      @(posedge clk); #1;
      if (c_rvalid) extra++;
    end
    check("rstmid no rvalid", 32'(extra), 32'd0);
    core_op("LW rst", 1'b0, 3'b010, 32'h10, 32'd0,
            4'hf, 32'd0, 32'h1234_AB01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
